// File: rtl/matrix_mult_4x4_complex_seq_ctrl.sv
// Sequencing controller for the 4x4 complex matrix multiplier datapath.
// Accepts A then B (32 complex elements, row-major) over a valid/ready stream,
// holds them on the wide operand buses, waits DP_LAT+1 cycles, captures the
// 16 complex results and streams them out over a valid/ready stream.
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   in_valid, in_ready            input element handshake
//   in_re, in_im      [W]         input element (A[0..15] then B[0..15])
//   out_valid, out_ready          result element handshake
//   out_re, out_im    [WO]        result element C[odx]
//   out_last                      high with C[3][3]
//   busy                          job in progress
//   dp_a_*, dp_b_*    [16*W]      operand buses, element (i,j) at (4i+j)*W
//   dp_c_re, dp_c_im  [16*WO]     datapath results, element (i,j) at (4i+j)*WO
`timescale 1ns/1ps
module matrix_mult_4x4_complex_seq_ctrl #(
  parameter int unsigned W      = 48,
  parameter int unsigned WO     = 2*W+3,
  parameter int unsigned DP_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_re,
  input  logic [W-1:0]      in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WO-1:0]     out_re,
  output logic [WO-1:0]     out_im,
  output logic              out_last,
  output logic              busy,
  output logic [16*W-1:0]   dp_a_re,
  output logic [16*W-1:0]   dp_a_im,
  output logic [16*W-1:0]   dp_b_re,
  output logic [16*W-1:0]   dp_b_im,
  input  logic [16*WO-1:0]  dp_c_re,
  input  logic [16*WO-1:0]  dp_c_im
);

  localparam int unsigned N  = 16;
  localparam int unsigned CW = (DP_LAT < 2) ? 1 : $clog2(DP_LAT + 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t          r_state;
  logic [4:0]      r_idx;
  logic [3:0]      r_odx;
  logic [CW-1:0]   r_wcnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [WO-1:0]   r_out_re;
  logic [WO-1:0]   r_out_im;
  logic            r_out_last;
  logic            r_busy;

  logic [W-1:0]    r_a_re [N];
  logic [W-1:0]    r_a_im [N];
  logic [W-1:0]    r_b_re [N];
  logic [W-1:0]    r_b_im [N];
  logic [WO-1:0]   r_c_re [N];
  logic [WO-1:0]   r_c_im [N];

  logic [WO-1:0]   w_c_re [N];
  logic [WO-1:0]   w_c_im [N];
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_capture;
  logic [3:0]      w_odx_nxt;

  // in_ready is only ever high in LOAD, so the fire needs no state qualifier
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_capture  = (r_state == S_COMPUTE) && (r_wcnt == CW'(DP_LAT));
  assign w_odx_nxt  = r_odx + 4'd1;

  // Pack operand registers onto the datapath buses, unpack results
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign dp_a_re[g*W +: W] = r_a_re[g];
    assign dp_a_im[g*W +: W] = r_a_im[g];
    assign dp_b_re[g*W +: W] = r_b_re[g];
    assign dp_b_im[g*W +: W] = r_b_im[g];
    assign w_c_re[g]         = dp_c_re[g*WO +: WO];
    assign w_c_im[g]         = dp_c_im[g*WO +: WO];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  // Operand registers: written at the accepting edge, idx[4] selects A/B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_a_re[i] <= '0;
        r_a_im[i] <= '0;
        r_b_re[i] <= '0;
        r_b_im[i] <= '0;
      end
    end else if (w_in_fire) begin
      if (!r_idx[4]) begin
        r_a_re[r_idx[3:0]] <= in_re;
        r_a_im[r_idx[3:0]] <= in_im;
      end else begin
        r_b_re[r_idx[3:0]] <= in_re;
        r_b_im[r_idx[3:0]] <= in_im;
      end
    end
  end

  // Result registers: snapshot of the whole datapath output at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_c_re[i] <= '0;
        r_c_im[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < N; i++) begin
        r_c_re[i] <= w_c_re[i];
        r_c_im[i] <= w_c_im[i];
      end
    end
  end

  // Job sequencer: LOAD -> COMPUTE -> DRAIN -> LOAD, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_idx       <= '0;
      r_odx       <= '0;
      r_wcnt      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_busy <= 1'b1;
            if (r_idx == 5'd31) begin
              r_state    <= S_COMPUTE;
              r_in_ready <= 1'b0;
              r_wcnt     <= '0;
              r_idx      <= '0;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_COMPUTE: begin
          if (w_capture) begin
            // first result comes straight from the datapath, later ones from r_c_*
            r_state     <= S_DRAIN;
            r_out_valid <= 1'b1;
            r_odx       <= '0;
            r_out_re    <= w_c_re[0];
            r_out_im    <= w_c_im[0];
            r_out_last  <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (r_odx == 4'd15) begin
              r_state     <= S_LOAD;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_odx       <= '0;
              r_idx       <= '0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_odx      <= w_odx_nxt;
              r_out_re   <= r_c_re[w_odx_nxt];
              r_out_im   <= r_c_im[w_odx_nxt];
              r_out_last <= (w_odx_nxt == 4'd15);
            end
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
